// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order imem reads, fetch queue, registered one-per-cycle issue to decode.
// Latency: response at edge E appears on instr at edge E+1; a taken branch flushes and drops stale responses.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [PC_W-1:0]           imem_req_addr,
    input  logic                      imem_rsp_valid,
    input  logic [15:0]               imem_rsp_data,
    input  logic                      stall,
    input  logic                      is_branch_taken,
    input  logic [PC_W-1:0]           branch_target,
    output logic [15:0]               instr,
    output logic [PC_W-1:0]           instr_pc,
    output logic                      instr_valid,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int              AW      = $clog2(FQ_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [PC_W-1:0] STEP    = PC_W'(PC_STEP);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FQ_DEPTH);

    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] rsp_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   inflight_d;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   wr_ptr_q;
    logic [CW-1:0]   rd_ptr_q;
    logic            started_q;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] instr_pc_q;
    logic            instr_valid_q;
    logic [15:0]     fq_dat [FQ_DEPTH];
    logic [PC_W-1:0] fq_pc  [FQ_DEPTH];
    logic            req_hs;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;

    // Queued plus outstanding words never exceed the queue size, so a response always has a slot.
    assign fq_count       = wr_ptr_q - rd_ptr_q;
    assign credit_used    = {1'b0, fq_count} + {1'b0, inflight_q};
    assign imem_req_valid = started_q && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && !is_branch_taken && (drop_cnt_q == '0);
    assign pop            = !is_branch_taken && !stall && (fq_count != '0);
    assign inflight_d     = inflight_q + CW'(req_hs) - CW'(imem_rsp_valid);

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            inflight_q    <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            started_q     <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            started_q  <= 1'b1;
            inflight_q <= inflight_d;
            if (is_branch_taken) begin
                // Everything still outstanding after this edge belongs to the old path.
                fetch_pc_q    <= branch_target;
                rsp_pc_q      <= branch_target;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                drop_cnt_q    <= inflight_d;
                instr_q       <= '0;
                instr_valid_q <= 1'b0;
            end else begin
                if (req_hs) begin
                    fetch_pc_q <= fetch_pc_q + STEP;
                end
                if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + STEP;
                    wr_ptr_q <= wr_ptr_q + CW'(1);
                end
                if (!stall) begin
                    if (pop) begin
                        instr_q       <= fq_dat[rd_ptr_q[AW-1:0]];
                        instr_pc_q    <= fq_pc[rd_ptr_q[AW-1:0]];
                        instr_valid_q <= 1'b1;
                        rd_ptr_q      <= rd_ptr_q + CW'(1);
                    end else begin
                        instr_q       <= '0;
                        instr_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_dat[wr_ptr_q[AW-1:0]] <= imem_rsp_data;
            fq_pc[wr_ptr_q[AW-1:0]]  <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: untagged in-order memory model with epoch tracking, scoreboard queue, directed scenarios.
module tb_fetch_unit;
    localparam logic [15:0] KEY = 16'hC3A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic        stall = 1'b0;
    logic        is_branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic [2:0]  fq_count;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .is_branch_taken(is_branch_taken), .branch_target(branch_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
        int          ep;
    } req_t;

    exp_t        exp_q[$];
    req_t        mq[$];
    logic [15:0] hs_log[$];
    int          lat = 1;
    int          cyc = 0;
    int          epoch = 0;
    logic [15:0] exp_addr = '0;
    logic        pend_v = 1'b0;
    logic [15:0] pend_addr = '0;
    logic        log_en = 1'b0;
    logic        mem_rdy = 1'b1;
    int          first_pc = -1;
    int          pops = 0;
    logic        lv = 1'b0;
    logic [15:0] ld = '0;
    logic [15:0] lp = '0;

    assign imem_req_ready = mem_rdy;

    // Memory model: records handshakes, retires the presented response, decides whether it survives.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            cyc = 0;
            pend_v = 1'b0;
            epoch++;
            exp_addr = 16'h0000;
        end else begin
            cyc++;
            if (imem_rsp_valid && mq.size() > 0) begin
                req_t r;
                r = mq.pop_front();
                if (r.ep == epoch && !is_branch_taken) begin
                    pend_v = 1'b1;
                    pend_addr = r.addr;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_addr);
                mq.push_back('{addr: imem_req_addr, due: cyc + lat - 1, ep: epoch});
                if (log_en && !is_branch_taken) hs_log.push_back(imem_req_addr);
                exp_addr = exp_addr + 16'd2;
            end
            if (is_branch_taken) begin
                epoch++;
                exp_addr = branch_target;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                exp_q.push_back({pend_addr, pend_addr ^ KEY});
                pend_v = 1'b0;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mq[0].addr ^ KEY;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = '0;
            end
        end
        check("inv_credit", (int'(fq_count) + int'(dut.inflight_q)) <= 4, 1);
        check("inv_drop", dut.drop_cnt_q <= dut.inflight_q, 1);
    end

    // Monitor: decides the expected output for this edge, then compares just after it.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            lv = 1'b0;
            ld = '0;
            lp = '0;
            first_pc = -1;
        end else begin
            if (is_branch_taken) begin
                exp_q.delete();
                lv = 1'b0;
                ld = '0;
                first_pc = -1;
            end else if (!stall) begin
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    lv = 1'b1;
                    ld = e.d;
                    lp = e.pc;
                    pops++;
                    if (first_pc < 0) first_pc = int'(e.pc);
                end else begin
                    lv = 1'b0;
                    ld = '0;
                end
            end
            #1;
            check("instr_valid", instr_valid, lv);
            check("instr", instr, ld);
            if (lv) check("instr_pc", instr_pc, lp);
        end
    end

    task automatic rst_seq();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] tgt);
        branch_target = tgt;
        is_branch_taken = 1'b1;
        @(negedge clk);
        is_branch_taken = 1'b0;
    endtask

    logic [15:0] wrap_tab [4];
    int          pops_before;

    initial begin
        wrap_tab = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_fq_count", fq_count, 0);

        // Basic streaming, 1-cycle memory
        @(negedge clk);
        reset = 1'b0;
        #1 check("t1_no_req_in_reset_exit", imem_req_valid, 0);
        @(negedge clk);
        check("t1_first_req_valid", imem_req_valid, 1);
        check("t1_first_req_addr", imem_req_addr, 16'h0000);
        @(negedge clk);
        check("t1_second_addr", imem_req_addr, 16'h0002);
        check("t1_valid_e1", instr_valid, 0);
        @(negedge clk);
        check("t1_valid_e2", instr_valid, 0);
        check("t1_fq_e2", fq_count, 1);
        @(negedge clk);
        check("t1_valid_e3", instr_valid, 1);
        check("t1_pc_e3", instr_pc, 16'h0000);
        repeat (6) @(negedge clk);

        // Stall fills the queue and stops requests; release drains in order
        stall = 1'b1;
        repeat (8) @(negedge clk);
        check("t2_req_blocked", imem_req_valid, 0);
        check("t2_fq_full", fq_count, 4);
        pops_before = pops;
        stall = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_drained", (pops - pops_before) >= 4, 1);

        // Redirect with two in flight, 3-cycle memory
        lat = 3;
        rst_seq();
        repeat (3) @(negedge clk);
        redirect(16'h0040);
        check("t3_drop_cnt", dut.drop_cnt_q, 3);
        repeat (15) @(negedge clk);
        check("t3_first_pc", first_pc, 32'h0040);

        // Redirect coinciding with a response and a request handshake
        lat = 1;
        rst_seq();
        repeat (5) @(negedge clk);
        redirect(16'h0100);
        check("t4_drop_cnt", dut.drop_cnt_q, 1);
        repeat (10) @(negedge clk);
        check("t4_first_pc", first_pc, 32'h0100);

        // PC wrap
        hs_log.delete();
        log_en = 1'b1;
        redirect(16'hFFFC);
        repeat (12) @(negedge clk);
        log_en = 1'b0;
        check("t5_log_size", hs_log.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            check("t5_wrap_addr", (i < hs_log.size()) ? hs_log[i] : 16'hDEAD, wrap_tab[i]);
        end
        check("t5_first_pc", first_pc, 32'hFFFC);

        // Reset mid-flight with the queue filling
        lat = 3;
        stall = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_pre_inflight", dut.inflight_q != 0, 1);
        reset = 1'b1;
        #1;
        check("t6_instr_valid", instr_valid, 0);
        check("t6_fq_count", fq_count, 0);
        check("t6_req_valid", imem_req_valid, 0);
        repeat (2) @(negedge clk);
        stall = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t6_req_after", imem_req_valid, 1);
        check("t6_addr_after", imem_req_addr, 16'h0000);
        repeat (12) @(negedge clk);
        check("t6_first_pc", first_pc, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
